// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset PC, NOP encoding and fetch queue entry type.
// Consumed by the fetch queue and its storage.
package cpu_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fq_mem.sv
// Fetch queue entry storage: one write port, one asynchronous read port.
// Contents are not reset; validity is tracked by the owner.
module fq_mem
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t  wdata,
    input  logic [AW-1:0] raddr,
    output fetch_entry_t  rdata
);

    fetch_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Circular fetch queue between fetch and decode, flushed on redirect.
// Define FETCH_QUEUE_BYPASS_EN for same-cycle pass-through when empty.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_instr,
    output logic          in_ready,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    input  logic          out_ready,
    input  logic          flush,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    fetch_entry_t  head;
    fetch_entry_t  wdata;
    logic          empty;
    logic          bypass;
    logic          bypass_take;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic          rd_en;

    assign empty = (cnt == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty && in_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid   = !empty || bypass;
    assign in_ready    = (cnt < FULL) || (out_valid && out_ready);
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    // A bypassed word consumed this cycle never touches storage.
    assign bypass_take = bypass && out_ready;
    assign wr_en       = push && !flush && !bypass_take;
    assign rd_en       = pop && !bypass_take;
    assign count       = cnt;

    assign wdata.pc    = in_pc;
    assign wdata.instr = in_instr;

    fq_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_comb begin
        out_pc    = RESET_PC;
        out_instr = NOP_INSTR;
        unique case (1'b1)
            bypass: begin
                out_pc    = in_pc;
                out_instr = in_instr;
            end
            !empty: begin
                out_pc    = head.pc;
                out_instr = head.instr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case (1'b1)
                (wr_en && !rd_en): cnt <= cnt + (AW + 1)'(1);
                (rd_en && !wr_en): cnt <= cnt - (AW + 1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed vector bench for fetch_queue (DEPTH=4).
// Each row drives one cycle and checks the outputs seen before its edge.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic        flush;
    logic [2:0]  count;

    int errors;
    int checks;

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic [2:0]  cnt;
        logic        ir;
        logic        ov;
        logic [31:0] opc;
        logic [31:0] oin;
    } vec_t;

    vec_t vecs[$];

    fetch_queue #(
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]};
    endfunction

    task automatic add(input logic r, input logic iv, input logic [31:0] pc,
                       input logic ordy, input logic fl, input int cnt,
                       input logic ir, input logic ov,
                       input logic [31:0] opc);
        vec_t v;
        v.rst_n = r;
        v.iv    = iv;
        v.pc    = pc;
        v.ordy  = ordy;
        v.fl    = fl;
        v.cnt   = 3'(cnt);
        v.ir    = ir;
        v.ov    = ov;
        v.opc   = ov ? opc : RPC;
        v.oin   = ov ? instr_of(opc) : 32'h0;
        vecs.push_back(v);
    endtask

    // push into an empty queue: visible now only when bypass is built in
    task automatic add_empty_push(input logic [31:0] pc);
        add(1, 1, pc, 0, 0, 0, 1, BYP, pc);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h",
                     name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset    = v.rst_n;
        in_valid = v.iv;
        in_pc    = v.pc;
        in_instr = instr_of(v.pc);
        out_ready = v.ordy;
        flush    = v.fl;
    endtask

    task automatic check_row(input vec_t v, input int i);
        chk("count", i, 32'(count), 32'(v.cnt));
        chk("in_ready", i, 32'(in_ready), 32'(v.ir));
        chk("out_valid", i, 32'(out_valid), 32'(v.ov));
        chk("out_pc", i, out_pc, v.opc);
        chk("out_instr", i, out_instr, v.oin);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // reset state, then fill with out_ready low
        add(1, 0, 0, 0, 0, 0, 1, 0, 0);
        add_empty_push(32'h3000);
        add(1, 1, 32'h3004, 0, 0, 1, 1, 1, 32'h3000);
        add(1, 1, 32'h3008, 0, 0, 2, 1, 1, 32'h3000);
        add(1, 1, 32'h300C, 0, 0, 3, 1, 1, 32'h3000);
        // full: push refused, head unchanged
        add(1, 1, 32'h3FF0, 0, 0, 4, 0, 1, 32'h3000);
        // full with push+pop for 8 cycles, pointers wrap twice
        for (int k = 0; k < 8; k++) begin
            add(1, 1, 32'h3010 + 32'(4 * k), 1, 0, 4, 1, 1,
                32'h3000 + 32'(4 * k));
        end
        add(1, 0, 0, 0, 0, 4, 0, 1, 32'h3020);
        // drain
        for (int k = 0; k < 4; k++) begin
            add(1, 0, 0, 1, 0, 4 - k, 1, 1, 32'h3020 + 32'(4 * k));
        end
        add(1, 0, 0, 0, 0, 0, 1, 0, 0);
        // three queued, flush with push and pop
        add_empty_push(32'h3100);
        add(1, 1, 32'h3104, 0, 0, 1, 1, 1, 32'h3100);
        add(1, 1, 32'h3108, 0, 0, 2, 1, 1, 32'h3100);
        add(1, 1, 32'h310C, 1, 1, 3, 1, 1, 32'h3100);
        add(1, 0, 0, 0, 0, 0, 1, 0, 0);
        // reset wins over flush and push with two queued
        add_empty_push(32'h3200);
        add(1, 1, 32'h3204, 0, 0, 1, 1, 1, 32'h3200);
        add(0, 1, 32'h3208, 0, 1, 2, 1, 1, 32'h3200);
        add(1, 0, 0, 0, 0, 0, 1, 0, 0);
        // post-reset push then pop shows the new word only
        add_empty_push(32'h3300);
        add(1, 0, 0, 1, 0, 1, 1, 1, 32'h3300);
        add(1, 0, 0, 0, 0, 0, 1, 0, 0);

        repeat (2) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            check_row(vecs[i], i);
        end

`ifdef FETCH_QUEUE_BYPASS_EN
        // empty queue, word consumed in the same cycle
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h3020;
        in_instr  = instr_of(32'h3020);
        out_ready = 1'b1;
        flush     = 1'b0;
        #2;
        chk("byp_valid", 900, 32'(out_valid), 32'd1);
        chk("byp_pc", 900, out_pc, 32'h3020);
        chk("byp_instr", 900, out_instr, instr_of(32'h3020));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("byp_count", 901, 32'(count), 32'd0);
        chk("byp_after", 901, 32'(out_valid), 32'd0);
`endif

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 SHALL have port in_valid  in  1  fetch stage presents a fetched word this cycle.
REQ-005 SHALL have port in_pc  in  32  PC of the fetched word.
REQ-006 SHALL have port in_instr  in  32  fetched instruction word.
REQ-007 SHALL have port in_ready  out  1  queue accepts a push; inverted, it drives the PC stop input.
REQ-008 SHALL have port out_valid  out  1  head entry valid for decode.
REQ-009 SHALL have port out_pc  out  32  head PC.
REQ-010 SHALL have port out_instr  out  32  head instruction.
REQ-011 SHALL have port out_ready  in  1  decode consumes the head this cycle (decode not stalled).
REQ-012 SHALL have port flush  in  1  redirect (taken branch, j, jal, jr); discard queued words.
REQ-013 SHALL have port count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 SHALL be a circular FIFO of {pc, instr} entries with wrapping read/write pointers of $clog2(DEPTH) bits.
REQ-015 SHALL push when in_valid && in_ready and pop when out_valid && out_ready, both taking effect at the next clock edge.
REQ-016 SHALL drive in_ready = (count < DEPTH) || (out_valid && out_ready), so a push and a pop are allowed in the same cycle when full.
REQ-017 SHALL leave count unchanged on a simultaneous push and pop, increment it on push only, and decrement it on pop only.
REQ-018 SHALL drive out_valid = (count != 0), with out_pc/out_instr taken from the head entry (registered-storage read, combinational mux).
REQ-019 SHALL drive out_pc = 32'h0000_3000 and out_instr = 32'h0000_0000 (NOP) while out_valid is 0.
REQ-020 SHALL, on flush, clear both pointers and set count to 0 at the next edge; a pop in the flush cycle still counts as completed, and a push in the flush cycle is dropped.
REQ-021 SHALL never overwrite an unread entry and never pop from an empty queue.
REQ-022 SHALL wrap the write pointer from DEPTH-1 to 0 and the read pointer likewise, without losing ordering.

Reset
REQ-023 SHALL, when reset is 0 at a rising edge, set both pointers to 0 and count to 0; out_valid is then 0, in_ready 1, out_pc 32'h0000_3000, out_instr 0.
REQ-024 SHALL give reset priority over flush, push and pop in the same cycle.
REQ-025 SHALL leave storage contents unreset; contents are never observable while the entries are invalid.

Configuration
REQ-026 SHALL support macro FETCH_QUEUE_BYPASS_EN.
- Defined: when the queue is empty and in_valid is 1 with flush 0, out_valid is 1 in the same cycle and outputs carry in_pc/in_instr. If out_ready is also 1, the word is consumed without being written and count stays 0.
- Undefined: no bypass; a pushed word appears at the outputs one cycle after the push, so minimum latency is 1 cycle.

Structure
REQ-027 SHALL take RESET_PC (32'h0000_3000) and NOP_INSTR (32'h0) from the shared package cpu_pkg, alongside a fetch_entry_t {pc, instr} typedef.
REQ-028 SHALL place entry storage in one sub-module fq_mem (DEPTH x 64-bit, one write port, one asynchronous read port); pointer and count logic stay in fetch_queue.

Verification
REQ-029 Reset then push PC 0x3000 through 0x300C with out_ready=0 -> count=4, in_ready=0; count is 1 after the first push and out_pc=0x3000 (bypass off).
REQ-030 Full queue, in_valid=1 and out_ready=1 for 8 cycles with PCs 0x3010 onward -> count stays 4, output order is 0x3000, 0x3004, ..., and pointers wrap with no loss.
REQ-031 Three entries queued, flush=1 with in_valid=1 and out_ready=1 -> head 0x3000 consumed, next cycle count=0, out_valid=0, out_pc=0x3000, out_instr=0.
REQ-032 reset=0 asserted together with flush and a push while 2 entries are queued -> next cycle count=0, in_ready=1, out_valid=0.
REQ-033 FETCH_QUEUE_BYPASS_EN defined, empty queue, in_valid=1, in_pc=0x3020, out_ready=1 -> same-cycle out_valid=1, out_pc=0x3020, and count stays 0.
